mem_wb_stage: RTL



---
 rtl/rv32i_mem_pkg.sv | 34 +++
 rtl/mem_wb_stage_load_align.sv | 25 ++
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the RV32I memory/write-back stage: access-size
// encodings, the stage FSM states and the byte-lane helpers.
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the byte enables alone pick the target bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and applies
// sign or zero extension according to the access size.
module load_align
    import rv32i_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            F3_B:    value = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   value = {24'd0, shifted[7:0]};
            F3_H:    value = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   value = {16'd0, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: performs data-memory loads and stores and drives the
// register file write port; ALU results pass through with one cycle of latency.
module mem_wb_stage
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_write_enable,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_write_data,
    output logic        mem_misaligned,
    output logic        mem_fault
);

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic        hold_we;
    logic [2:0]  hold_funct3;
    logic [4:0]  hold_rd;
    logic [31:0] hold_addr, hold_wdata, load_value;
    logic        mem_op, illegal, misaligned, accept, timeout;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (hold_addr[1:0]),
        .funct3 (hold_funct3),
        .value  (load_value)
    );

    always_comb begin
        mem_op     = ex_mem_read || ex_mem_write;
        illegal    = (ex_mem_read && ex_mem_write)
                  || (ex_funct3 inside {3'b011, 3'b110, 3'b111})
                  || (ex_mem_write && ex_funct3[2]);
        misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0])
                  || ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
        accept     = ex_valid && mem_op && !illegal && !misaligned;
        timeout    = (wait_cnt == 8'(MAX_WAIT - 1));
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (dmem_gnt && hold_we) state_next = IDLE;
                     else if (timeout)        state_next = IDLE;
                     else if (dmem_gnt)       state_next = WAIT;
            WAIT:    if (dmem_rvalid || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A completing store or load in the final allowed cycle wins over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            hold_we         <= 1'b0;
            hold_funct3     <= '0;
            hold_rd         <= '0;
            hold_addr       <= '0;
            hold_wdata      <= '0;
            wb_write_enable <= 1'b0;
            wb_rd           <= '0;
            wb_write_data   <= '0;
            mem_misaligned  <= 1'b0;
            mem_fault       <= 1'b0;
        end else begin
            state           <= state_next;
            wait_cnt        <= (state == IDLE) ? 8'd0 : wait_cnt + 8'd1;
            wb_write_enable <= 1'b0;
            mem_misaligned  <= 1'b0;
            mem_fault       <= 1'b0;
            case (state)
                IDLE: if (ex_valid) begin
                    if (!mem_op) begin
                        if (ex_reg_write && (ex_rd != 5'd0)) begin
                            wb_write_enable <= 1'b1;
                            wb_rd           <= ex_rd;
                            wb_write_data   <= ex_alu_result;
                        end
                    end else if (illegal) begin
                        mem_fault <= 1'b1;
                    end else if (misaligned) begin
                        mem_misaligned <= 1'b1;
                    end else begin
                        hold_we     <= ex_mem_write;
                        hold_funct3 <= ex_funct3;
                        hold_rd     <= ex_rd;
                        hold_addr   <= ex_alu_result;
                        hold_wdata  <= store_lanes(ex_funct3, ex_store_data);
                    end
                end
                REQ: if (!(dmem_gnt && hold_we) && timeout) mem_fault <= 1'b1;
                WAIT: if (dmem_rvalid) begin
                    if (hold_rd != 5'd0) begin
                        wb_write_enable <= 1'b1;
                        wb_rd           <= hold_rd;
                        wb_write_data   <= load_value;
                    end
                end else if (timeout) begin
                    mem_fault <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_stall  = (state != IDLE);
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req && hold_we;
    assign dmem_addr  = {hold_addr[31:2], 2'b00};
    assign dmem_be    = byte_enable(hold_funct3, hold_addr[1:0]);
    assign dmem_wdata = hold_wdata;

endmodule
